// File: rtl/rom_req_arbiter_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : rom_arb_pkg                                            |
// | Description : Shared types and widths for the tile-ROM request       |
// |               arbiter (state encoding, default ROM geometry).        |
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
package rom_arb_pkg;

  // Arbiter states: SYNC re-aligns the ROM toggle after reset.
  typedef enum logic [1:0] {
    ST_SYNC = 2'd0,
    ST_IDLE = 2'd1,
    ST_WAIT = 2'd2
  } state_t;

  localparam int ROM_ADDR_W = 21;
  localparam int ROM_DATA_W = 32;

endpackage
`default_nettype wire

// File: rtl/rom_req_arbiter_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : rom_req_arbiter_if                                     |
// | Description : Requester-side and ROM-side toggle handshake bundle.   |
// |               slave = arbiter view, master = environment view.       |
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
interface rom_req_arbiter_if
  import rom_arb_pkg::*;
#(
  parameter int NUM_CH = 4,
  parameter int ADDR_W = ROM_ADDR_W,
  parameter int DATA_W = ROM_DATA_W
);

  logic [NUM_CH-1:0]        ch_req;
  logic [NUM_CH*ADDR_W-1:0] ch_addr;
  logic [NUM_CH-1:0]        ch_ack;
  logic [NUM_CH*DATA_W-1:0] ch_data;
  logic [ADDR_W-1:0]        mem_addr;
  logic                     mem_req;
  logic                     mem_ack;
  logic [DATA_W-1:0]        mem_data;
  logic                     busy;

  modport slave (
    input  ch_req, ch_addr, mem_ack, mem_data,
    output ch_ack, ch_data, mem_addr, mem_req, busy
  );

  modport master (
    output ch_req, ch_addr, mem_ack, mem_data,
    input  ch_ack, ch_data, mem_addr, mem_req, busy
  );

endinterface
`default_nettype wire

// File: rtl/rom_req_arbiter_pick.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : rom_arb_pick                                           |
// | Description : Combinational selector. Scans the pending vector from  |
// |               'start' upwards (wrapping) and returns the first hit.  |
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
module rom_arb_pick #(
  parameter int NUM_CH = 4,
  parameter int IDX_W  = 2
) (
  input  logic [NUM_CH-1:0] pending,
  input  logic [IDX_W-1:0]  start,
  output logic [IDX_W-1:0]  winner,
  output logic              any_valid
);

  int w_j;

  // First pending channel at or after 'start', wrapping modulo NUM_CH.
  always_comb begin
    winner    = '0;
    any_valid = 1'b0;
    w_j       = 0;
    for (int i = 0; i < NUM_CH; i++) begin
      w_j = int'(start) + i;
      if (w_j >= NUM_CH) begin
        w_j = w_j - NUM_CH;
      end
      if (!any_valid && pending[w_j[IDX_W-1:0]]) begin
        winner    = w_j[IDX_W-1:0];
        any_valid = 1'b1;
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/rom_req_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : rom_req_arbiter                                        |
// | Description : Shares one tile-ROM read port between NUM_CH toggle-   |
// |               handshake requesters; one outstanding read at a time.  |
// |               Build option ROM_ARB_RR_EN selects round-robin         |
// |               arbitration, otherwise fixed priority (ch0 highest).   |
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
module rom_req_arbiter
  import rom_arb_pkg::*;
#(
  parameter int NUM_CH = 4,
  parameter int ADDR_W = ROM_ADDR_W,
  parameter int DATA_W = ROM_DATA_W
) (
  input  logic              clk,
  input  logic              reset,
  rom_req_arbiter_if.slave  bus
);

  localparam int IDX_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

  state_t                   r_state;
  state_t                   w_next;
  logic                     w_grant;
  logic                     w_done;

  logic [NUM_CH-1:0]        r_ch_ack;
  logic [NUM_CH*DATA_W-1:0] r_ch_data;
  logic [ADDR_W-1:0]        r_mem_addr;
  logic                     r_mem_req;
  logic                     r_busy;
  logic [IDX_W-1:0]         r_gnt;

  logic [NUM_CH-1:0]        w_pending;
  logic [IDX_W-1:0]         w_start;
  logic [IDX_W-1:0]         w_winner;
  logic                     w_any;
  logic                     w_mem_match;

  assign w_pending   = bus.ch_req ^ r_ch_ack;
  assign w_mem_match = (bus.mem_ack == r_mem_req);

`ifdef ROM_ARB_RR_EN
  logic [IDX_W-1:0] r_last_grant;

  // Search begins one past the most recent winner.
  assign w_start = (r_last_grant == IDX_W'(NUM_CH - 1)) ? '0 : r_last_grant + 1'b1;

  // Round-robin pointer follows each grant.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_last_grant <= '0;
    end else if (w_grant) begin
      r_last_grant <= w_winner;
    end
  end
`else
  assign w_start = '0;
`endif

  rom_arb_pick #(
    .NUM_CH (NUM_CH),
    .IDX_W  (IDX_W)
  ) u_pick (
    .pending   (w_pending),
    .start     (w_start),
    .winner    (w_winner),
    .any_valid (w_any)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= ST_SYNC;
    end else begin
      r_state <= w_next;
    end
  end

  // Next-state and grant/complete strobes; mem_ack is only looked at in SYNC and WAIT.
  always_comb begin
    w_next  = r_state;
    w_grant = 1'b0;
    w_done  = 1'b0;
    case (r_state)
      ST_SYNC: begin
        if (w_mem_match) begin
          w_next = ST_IDLE;
        end
      end
      ST_IDLE: begin
        if (w_any) begin
          w_next  = ST_WAIT;
          w_grant = 1'b1;
        end
      end
      ST_WAIT: begin
        if (w_mem_match) begin
          w_next = ST_IDLE;
          w_done = 1'b1;
        end
      end
      default: begin
        w_next = ST_SYNC;
      end
    endcase
  end

  // Datapath: latch address on grant, return word and close handshake on completion.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_ch_ack   <= '0;
      r_ch_data  <= '0;
      r_mem_addr <= '0;
      r_mem_req  <= 1'b0;
      r_gnt      <= '0;
      r_busy     <= 1'b0;
    end else begin
      r_busy <= (w_next == ST_WAIT);
      if (w_grant) begin
        r_mem_addr <= bus.ch_addr[int'(w_winner)*ADDR_W +: ADDR_W];
        r_mem_req  <= ~r_mem_req;
        r_gnt      <= w_winner;
      end
      if (w_done) begin
        // Copying req (not toggling ack) folds any extra toggles into one request.
        r_ch_ack[r_gnt]                         <= bus.ch_req[r_gnt];
        r_ch_data[int'(r_gnt)*DATA_W +: DATA_W] <= bus.mem_data;
      end
    end
  end

  assign bus.ch_ack   = r_ch_ack;
  assign bus.ch_data  = r_ch_data;
  assign bus.mem_addr = r_mem_addr;
  assign bus.mem_req  = r_mem_req;
  assign bus.busy     = r_busy;

endmodule
`default_nettype wire

// File: tb/tb_rom_req_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : tb_rom_req_arbiter                                     |
// | Description : Directed bench for rom_req_arbiter with a simple ROM   |
// |               responder (data = 0xA5000000 | addr unless fixed).    |
// |               Honours ROM_ARB_RR_EN for the arbitration-order cases. |
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
module tb_rom_req_arbiter;

  localparam int NCH = 4;
  localparam int AW  = 21;
  localparam int DW  = 32;

  logic clk;
  logic reset;

  rom_req_arbiter_if #(.NUM_CH(NCH), .ADDR_W(AW), .DATA_W(DW)) bus ();

  rom_req_arbiter #(.NUM_CH(NCH), .ADDR_W(AW), .DATA_W(DW)) u_dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  // ROM responder controls.
  bit          rom_auto  = 1'b1;
  int          rom_lat   = 1;
  bit          rom_fix   = 1'b0;
  logic [31:0] rom_word  = 32'h0;
  logic        rom_force = 1'b0;
  int          rom_cnt   = 0;

  // Grant counter: every mem_req change.
  int   n_gnt   = 0;
  logic prev_mr = 1'b0;

  int   snap;
  logic [20:0] first_addr;
  logic [20:0] second_addr;
  logic [31:0] first_data;

`ifdef ROM_ARB_RR_EN
  int comp[NCH];
  bit outst[NCH];
  int issued;
  int total;
  int guard;
`endif

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic set_addr(input int ch, input logic [20:0] a);
    bus.ch_addr[ch*AW +: AW] = a;
  endtask

  function automatic logic [31:0] data_of(input int ch);
    logic [NCH*DW-1:0] v;
    v = bus.ch_data;
    return v[ch*DW +: DW];
  endfunction

  task automatic wait_ack(input string tag, input int ch, input logic val, input int max);
    int k;
    k = 0;
    while (bus.ch_ack[ch] !== val && k < max) begin
      tick(1);
      k++;
    end
    check_eq(tag, 64'(bus.ch_ack[ch]), 64'(val));
  endtask

  // ROM side: acknowledges rom_lat samples after seeing a new request.
  initial begin
    bus.mem_ack  = 1'b0;
    bus.mem_data = '0;
    forever begin
      @(posedge clk);
      #2;
      if (rom_auto) begin
        if (bus.mem_req != bus.mem_ack) begin
          rom_cnt++;
          if (rom_cnt >= rom_lat) begin
            bus.mem_data = rom_fix ? rom_word : (32'hA500_0000 | 32'(bus.mem_addr));
            bus.mem_ack  = bus.mem_req;
            rom_cnt      = 0;
          end
        end else begin
          rom_cnt = 0;
        end
      end else begin
        bus.mem_ack = rom_force;
        rom_cnt     = 0;
      end
    end
  end

  // Count ROM requests issued.
  initial begin
    forever begin
      @(negedge clk);
      if (bus.mem_req !== prev_mr) begin
        n_gnt++;
        prev_mr = bus.mem_req;
      end
    end
  end

  initial begin
    reset       = 1'b1;
    bus.ch_req  = '0;
    bus.ch_addr = '0;
    tick(3);

    // Reset state.
    check_eq("rst_ack",   64'(bus.ch_ack), 64'h0);
    check_eq("rst_data",  64'(bus.ch_data[63:0]), 64'h0);
    check_eq("rst_data_hi", 64'(bus.ch_data[127:64]), 64'h0);
    check_eq("rst_mreq",  64'(bus.mem_req), 64'h0);
    check_eq("rst_maddr", 64'(bus.mem_addr), 64'h0);
    check_eq("rst_busy",  64'(bus.busy), 64'h0);
    reset = 1'b0;
    tick(1);

    // Single request on ch1, ROM latency 3 with fixed word.
    rom_lat  = 3;
    rom_fix  = 1'b1;
    rom_word = 32'hDEADBEEF;
    set_addr(1, 21'h01234);
    bus.ch_req[1] = 1'b1;
    tick(1);
    check_eq("single_maddr", 64'(bus.mem_addr), 64'h01234);
    check_eq("single_mreq",  64'(bus.mem_req), 64'h1);
    check_eq("single_busy",  64'(bus.busy), 64'h1);
    tick(2);
    check_eq("single_ack_early", 64'(bus.ch_ack[1]), 64'h0);
    tick(1);
    check_eq("single_ack",  64'(bus.ch_ack[1]), 64'h1);
    check_eq("single_data", 64'(data_of(1)), 64'hDEADBEEF);
    check_eq("single_busy_done", 64'(bus.busy), 64'h0);
    check_eq("single_other", 64'(data_of(0)), 64'h0);
    rom_fix = 1'b0;

    // Simultaneous ch0 + ch2, zero-wait ROM.
    rom_lat = 1;
    set_addr(0, 21'h00100);
    set_addr(2, 21'h00300);
    bus.ch_req[0] = 1'b1;
    bus.ch_req[2] = 1'b1;
`ifdef ROM_ARB_RR_EN
    first_addr  = 21'h00300;
    second_addr = 21'h00100;
    first_data  = 32'hA500_0300;
`else
    first_addr  = 21'h00100;
    second_addr = 21'h00300;
    first_data  = 32'hA500_0100;
`endif
    tick(1);
    check_eq("simul_first_addr", 64'(bus.mem_addr), 64'(first_addr));
    tick(1);
`ifdef ROM_ARB_RR_EN
    check_eq("simul_first_data", 64'(data_of(2)), 64'(first_data));
`else
    check_eq("simul_first_data", 64'(data_of(0)), 64'(first_data));
`endif
    check_eq("simul_idle_busy", 64'(bus.busy), 64'h0);
    tick(1);
    check_eq("simul_second_addr", 64'(bus.mem_addr), 64'(second_addr));
    check_eq("simul_second_busy", 64'(bus.busy), 64'h1);
    tick(1);
    check_eq("simul_acks", 64'(bus.ch_ack), 64'h7);
    check_eq("simul_d0", 64'(data_of(0)), 64'hA500_0100);
    check_eq("simul_d2", 64'(data_of(2)), 64'hA500_0300);

    // ch3 arrives while ch0 is outstanding.
    rom_lat = 4;
    set_addr(0, 21'h00400);
    bus.ch_req[0] = 1'b0;
    tick(1);
    set_addr(3, 21'h00700);
    bus.ch_req[3] = 1'b1;
    tick(1);
    check_eq("dur_wait_addr", 64'(bus.mem_addr), 64'h00400);
    tick(3);
    check_eq("dur_ack0", 64'(bus.ch_ack[0]), 64'h0);
    check_eq("dur_d0",   64'(data_of(0)), 64'hA500_0400);
    check_eq("dur_idle", 64'(bus.busy), 64'h0);
    tick(1);
    check_eq("dur_gnt3_addr", 64'(bus.mem_addr), 64'h00700);
    check_eq("dur_gnt3_busy", 64'(bus.busy), 64'h1);
    wait_ack("dur_ack3", 3, 1'b1, 20);
    check_eq("dur_d3", 64'(data_of(3)), 64'hA500_0700);
    check_eq("dur_d0_kept", 64'(data_of(0)), 64'hA500_0400);
    tick(2);

    // Double toggle on ch1 while pending.
    snap = n_gnt;
    set_addr(1, 21'h00555);
    bus.ch_req[1] = 1'b0;
    tick(1);
    bus.ch_req[1] = 1'b1;
    tick(1);
    bus.ch_req[1] = 1'b0;
    wait_ack("dbl_ack", 1, 1'b0, 20);
    tick(4);
    check_eq("dbl_ack_eq_req", 64'(bus.ch_ack[1]), 64'(bus.ch_req[1]));
    check_eq("dbl_one_read", 64'(n_gnt - snap), 64'd1);
    check_eq("dbl_data", 64'(data_of(1)), 64'hA500_0555);
    check_eq("dbl_busy", 64'(bus.busy), 64'h0);

    // Reset during WAIT with mem_ack high.
    rom_auto  = 1'b0;
    rom_force = 1'b0;
    set_addr(2, 21'h00222);
    bus.ch_req[2] = 1'b0;
    tick(1);
    check_eq("rmt_mreq_hi", 64'(bus.mem_req), 64'h1);
    rom_force = 1'b1;
    reset     = 1'b1;
    tick(1);
    check_eq("rmt_mreq_lo", 64'(bus.mem_req), 64'h0);
    check_eq("rmt_busy",    64'(bus.busy), 64'h0);
    check_eq("rmt_ack",     64'(bus.ch_ack), 64'h0);
    reset = 1'b0;
    tick(1);
    snap = n_gnt;
    tick(3);
    check_eq("rmt_sync_nogrant", 64'(n_gnt - snap), 64'd0);
    check_eq("rmt_sync_mreq", 64'(bus.mem_req), 64'h0);
    check_eq("rmt_sync_maddr", 64'(bus.mem_addr), 64'h0);
    rom_force = 1'b0;
    tick(1);
    check_eq("rmt_idle_busy", 64'(bus.busy), 64'h0);
    tick(1);
    check_eq("rmt_regrant_mreq", 64'(bus.mem_req), 64'h1);
    check_eq("rmt_regrant_addr", 64'(bus.mem_addr), 64'h00700);
    rom_lat  = 1;
    rom_auto = 1'b1;
    wait_ack("rmt_ack3", 3, 1'b1, 20);
    tick(2);

`ifdef ROM_ARB_RR_EN
    // All channels re-request continuously for 40 transfers.
    issued = 0;
    total  = 0;
    guard  = 0;
    for (int i = 0; i < NCH; i++) begin
      comp[i]  = 0;
      outst[i] = 1'b0;
      set_addr(i, 21'(32'h01000 + i));
    end
    while (total < 40 && guard < 400) begin
      for (int i = 0; i < NCH; i++) begin
        if (outst[i] && bus.ch_ack[i] == bus.ch_req[i]) begin
          comp[i]++;
          total++;
          outst[i] = 1'b0;
        end
        if (!outst[i] && issued < 40) begin
          bus.ch_req[i] = ~bus.ch_req[i];
          outst[i] = 1'b1;
          issued++;
        end
      end
      tick(1);
      guard++;
    end
    check_eq("rr_total", 64'(total), 64'd40);
    for (int i = 0; i < NCH; i++) begin
      check_eq($sformatf("rr_ch%0d_count", i), 64'(comp[i]), 64'd10);
    end
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
